// File: rtl/datapath_gen.sv
// ============================================================================
// Module  : datapath_gen
// Brief   : Register-file / accumulator datapath with an 8-function ALU and a
//           repeat sequencer driven by a start/busy/done handshake.
//           Optional feature macro: DATAPATH_SAT_EN (saturating ADD/SUB).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_gen #(
  parameter int WIDTH = 4,
  parameter int NREG  = 3,
  parameter int CNTW  = 4,
  localparam int AW   = (NREG > 2) ? $clog2(NREG) : 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             wsel,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    rsel,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             acc_we,
  input  logic             start,
  input  logic [CNTW-1:0]  count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_PASSB = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_NOTA  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rsel_q, rsel_d;
  logic             cin_q, cin_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       alu_op;
  logic [AW-1:0]    alu_rsel;
  logic             alu_cin;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  // During a run the ALU is steered by the values captured at start.
  assign alu_op   = (state_q == S_RUN) ? op_q   : op;
  assign alu_rsel = (state_q == S_RUN) ? rsel_q : rsel;
  assign alu_cin  = (state_q == S_RUN) ? cin_q  : cin;

  always_comb begin
    b_op = '0;
    for (int i = 0; i < NREG; i++) begin
      if (alu_rsel == AW'(i)) b_op = regs_q[i];
    end
  end

  assign sum_w = {1'b0, acc_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, alu_cin};
  assign dif_w = {1'b0, acc_q} - {1'b0, b_op};

  always_comb begin
    alu_res = acc_q;
    alu_c   = 1'b0;
    case (alu_op)
      OP_PASSA: alu_res = acc_q;
      OP_PASSB: alu_res = b_op;
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
`ifdef DATAPATH_SAT_EN
        if (sum_w[WIDTH]) alu_res = '1;
`endif
      end
      OP_SUB: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
`ifdef DATAPATH_SAT_EN
        if (dif_w[WIDTH]) alu_res = '0;
`endif
      end
      OP_AND:  alu_res = acc_q & b_op;
      OP_OR:   alu_res = acc_q | b_op;
      OP_XOR:  alu_res = acc_q ^ b_op;
      OP_NOTA: alu_res = ~acc_q;
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    regs_d  = regs_q;
    op_d    = op_q;
    rsel_d  = rsel_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        // Writes land in the start cycle too, so a run sees the new value.
        if (we) begin
          for (int i = 0; i < NREG; i++) begin
            if (waddr == AW'(i)) regs_d[i] = wsel ? acc_q : din;
          end
        end
        if (start) begin
          if (count != '0) begin
            op_d    = op;
            rsel_d  = rsel;
            cin_d   = cin;
            cnt_d   = count;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else if (acc_we) begin
          acc_d   = alu_res;
          carry_d = alu_c;
        end
      end
      S_RUN: begin
        acc_d   = alu_res;
        carry_d = alu_c;
        cnt_d   = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= '0;
      rsel_q  <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      rsel_q  <= rsel_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign acc   = acc_q;
  assign carry = carry_q;
  assign zero  = (acc_q == '0);
  assign dout  = regs_q[NREG-1];

endmodule

`default_nettype wire

// File: tb/tb_datapath_gen.sv
// ============================================================================
// Module  : tb_datapath_gen
// Brief   : Randomized self-checking bench for datapath_gen (WIDTH=4, NREG=3)
//           against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_gen;

  localparam int W    = 4;
  localparam int NR   = 3;
  localparam int MASK = (1 << W) - 1;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] din;
  logic       wsel;
  logic       we;
  logic [1:0] waddr;
  logic [1:0] rsel;
  logic [2:0] op;
  logic       cin;
  logic       acc_we;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [3:0] acc;
  logic       carry;
  logic       zero;
  logic [3:0] dout;

  datapath_gen #(.WIDTH(4), .NREG(3), .CNTW(4)) dut (
    .clock(clock), .clear(clear), .din(din), .wsel(wsel), .we(we),
    .waddr(waddr), .rsel(rsel), .op(op), .cin(cin), .acc_we(acc_we),
    .start(start), .count(count), .busy(busy), .done(done), .acc(acc),
    .carry(carry), .zero(zero), .dout(dout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  int m_acc;
  int m_carry;
  int m_regs [NR];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    din = '0; wsel = 0; we = 0; waddr = '0; rsel = '0; op = '0;
    cin = 0; acc_we = 0; start = 0; count = '0;
  endtask

  function automatic int bval(input int rs);
    return (rs < NR) ? m_regs[rs] : 0;
  endfunction

  // Reference ALU from the function table, using plain integer arithmetic.
  task automatic alu_ref(input int f, input int a, input int b, input int ci,
                         output int r, output int c);
    int s;
    c = 0;
    case (f)
      0: r = a;
      1: r = b;
      2: begin
        s = a + b + ci;
        c = (s > MASK) ? 1 : 0;
`ifdef DATAPATH_SAT_EN
        r = c ? MASK : s;
`else
        r = s & MASK;
`endif
      end
      3: begin
        c = (a < b) ? 1 : 0;
`ifdef DATAPATH_SAT_EN
        r = c ? 0 : a - b;
`else
        r = (a - b) & MASK;
`endif
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = (~a) & MASK;
    endcase
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".acc"},   int'(acc),   m_acc);
    check_eq({tag, ".carry"}, int'(carry), m_carry);
    check_eq({tag, ".zero"},  int'(zero),  (m_acc == 0) ? 1 : 0);
    check_eq({tag, ".dout"},  int'(dout),  m_regs[NR-1]);
    check_eq({tag, ".busy"},  int'(busy),  0);
    check_eq({tag, ".done"},  int'(done),  0);
  endtask

  task automatic idle_cycle(input string tag, input int d_we, input int d_wsel,
                            input int d_wa, input int d_din, input int d_aw,
                            input int d_op, input int d_rs, input int d_ci);
    int r, c, old_acc;
    din = 4'(d_din); wsel = d_wsel[0]; we = d_we[0]; waddr = 2'(d_wa);
    rsel = 2'(d_rs); op = 3'(d_op); cin = d_ci[0]; acc_we = d_aw[0];
    start = 0; count = '0;
    tick();
    old_acc = m_acc;
    if (d_aw != 0) begin
      alu_ref(d_op, m_acc, bval(d_rs), d_ci, r, c);
      m_acc = r; m_carry = c;
    end
    if (d_we != 0 && d_wa < NR) m_regs[d_wa] = (d_wsel != 0) ? old_acc : d_din;
    set_idle();
    check_state(tag);
  endtask

  task automatic junk_inputs(input bit junk);
    op = 3'($urandom_range(0, 7)); rsel = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1)); count = 4'($urandom_range(0, 15));
    start = junk; acc_we = junk; we = junk; din = 4'd7; wsel = 1'($urandom_range(0, 1));
    waddr = 2'($urandom_range(0, 2));
  endtask

  task automatic do_run(input string tag, input int f, input int rs, input int ci,
                        input int n, input bit junk, input bit aw, input bit dw,
                        input int wa, input int d);
    int r, c;
    op = 3'(f); rsel = 2'(rs); cin = ci[0]; count = 4'(n); start = 1;
    acc_we = aw; we = dw; waddr = 2'(wa); din = 4'(d); wsel = 0;
    tick();
    if (dw && wa < NR) m_regs[wa] = d;
    for (int k = 0; k < n; k++) begin
      junk_inputs(junk);
      check_eq({tag, ".busy"}, int'(busy), 1);
      check_eq({tag, ".done"}, int'(done), 0);
      tick();
      alu_ref(f, m_acc, bval(rs), ci, r, c);
      m_acc = r; m_carry = c;
      check_eq({tag, ".step_acc"},   int'(acc),   m_acc);
      check_eq({tag, ".step_carry"}, int'(carry), m_carry);
    end
    junk_inputs(junk);
    check_eq({tag, ".done_pulse"}, int'(done), 1);
    check_eq({tag, ".done_busy"},  int'(busy), 0);
    check_eq({tag, ".done_acc"},   int'(acc),  m_acc);
    tick();
    set_idle();
    check_state({tag, ".after"});
  endtask

  initial begin
    set_idle();
    clear = 0;
    m_acc = 0; m_carry = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    tick();
    tick();
    check_state("reset");
    clear = 1;
    tick();

    // Preload registers, then abort a count=9 run with clear in cycle 3.
    idle_cycle("pre0", 1, 0, 0, 9, 0, 0, 0, 0);
    idle_cycle("pre1", 1, 0, 1, 5, 0, 0, 0, 0);
    idle_cycle("pre2", 1, 0, 2, 11, 0, 0, 0, 0);
    op = 3'b010; rsel = 2'd1; cin = 0; count = 4'd9; start = 1;
    tick();
    set_idle();
    tick();
    tick();
    clear = 0;
    #2;
    check_eq("rst_mid.busy",  int'(busy),  0);
    check_eq("rst_mid.done",  int'(done),  0);
    check_eq("rst_mid.acc",   int'(acc),   0);
    check_eq("rst_mid.carry", int'(carry), 0);
    check_eq("rst_mid.zero",  int'(zero),  1);
    check_eq("rst_mid.dout",  int'(dout),  0);
    #1;
    clear = 1;
    m_acc = 0; m_carry = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    tick();
    check_state("rst_after");
    idle_cycle("rd_r0", 0, 0, 0, 0, 1, 1, 0, 0);
    idle_cycle("rd_r1", 0, 0, 0, 0, 1, 1, 1, 0);

    // Load / pass / write-back from acc.
    idle_cycle("load_r0", 1, 0, 0, 5, 0, 0, 0, 0);
    idle_cycle("passb",   0, 0, 0, 0, 1, 1, 0, 0);
    check_eq("passb.acc5", int'(acc), 5);
    idle_cycle("wb_r2",   1, 1, 2, 0, 0, 0, 0, 0);
    check_eq("wb_r2.dout5", int'(dout), 5);

    // Multiply 3 x 4 by repeated ADD.
    idle_cycle("clr_acc", 0, 0, 0, 0, 1, 1, 3, 0);
    idle_cycle("ld_r1",   1, 0, 1, 3, 0, 0, 0, 0);
    do_run("mul", 2, 1, 0, 4, 0, 0, 0, 0, 0);
    check_eq("mul.acc12", int'(acc), 12);

    // Overflow and borrow.
    idle_cycle("ld_r0_3",  1, 0, 0, 3, 0, 0, 0, 0);
    idle_cycle("ld_r1_14", 1, 0, 1, 14, 0, 0, 0, 0);
    idle_cycle("acc14",    0, 0, 0, 0, 1, 1, 1, 0);
    idle_cycle("add_ovf",  0, 0, 0, 0, 1, 2, 0, 0);
    idle_cycle("ld_r1_2",  1, 0, 1, 2, 0, 0, 0, 0);
    idle_cycle("acc2",     0, 0, 0, 0, 1, 1, 1, 0);
    idle_cycle("sub_brw",  0, 0, 0, 0, 1, 3, 0, 0);

    // Handshake edge cases.
    do_run("cnt0",     2, 0, 1, 0, 0, 0, 0, 0, 0);
    do_run("junk",     2, 0, 0, 3, 1, 0, 0, 0, 0);
    do_run("start_aw", 7, 0, 0, 1, 0, 1, 1, 2, 6);
    idle_cycle("oor_add", 0, 0, 0, 0, 1, 2, 3, 1);
    idle_cycle("oor_wr",  1, 0, 3, 9, 0, 0, 0, 0);

    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) < 6)
        idle_cycle("rnd_idle", $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1));
      else
        do_run("rnd_run", $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 15));
    end

    for (int i = 0; i < NR + 1; i++) idle_cycle("final_rd", 0, 0, 0, 0, 1, 1, i, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
